// File: rtl/sar_pkg.sv
// Shared SAR definitions: interface FSM states and the code width used with sar_fsm.
package sar_pkg;

  localparam int unsigned SAR_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SAMPLE,
    DECIDE
  } sar_if_state_t;

endpackage

// File: rtl/sar_sync.sv
// Multi-flop single-bit synchronizer for the asynchronous comparator output.
module sar_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; only the last flop is observed.
  always_ff @(posedge clk) begin
    if (!reset) chain <= '0;
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sar_dac_comp_iface.sv
// Analog-side responder for the SAR controller: loads each trial code into the DAC,
// waits for settling, majority-votes the synchronized comparator and reports the
// decision; also captures the final result on the rising edge of done.
module sar_dac_comp_iface
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = SAR_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_SAMPLES   = 3,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sar_trial_value,
  input  logic             done,
  input  logic             comp_raw,
  output logic [WIDTH-1:0] dac_code,
  output logic             dac_load,
  output logic             comp_out,
  output logic             comp_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy
);

  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SMP_W  = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned VOTE_W = $clog2(NUM_SAMPLES + 1);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0]  SAMPLE_LAST = SMP_W'(NUM_SAMPLES - 1);
  localparam logic [VOTE_W-1:0] VOTE_HALF   = VOTE_W'(NUM_SAMPLES / 2);

  sar_if_state_t     state, state_d;
  logic [SET_W-1:0]  settle_cnt, settle_cnt_d;
  logic [SMP_W-1:0]  sample_cnt, sample_cnt_d;
  logic [VOTE_W-1:0] ones, ones_d;
  logic              first_trial, first_trial_d;
  logic              done_q;

  logic [WIDTH-1:0]  dac_code_d, result_d;
  logic              dac_load_d, comp_out_d, comp_valid_d, result_valid_d, busy_d;

  logic              comp_sync;
  logic              done_rise_c;
  logic              trial_diff_c;

  sar_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (comp_raw),
    .q     (comp_sync)
  );

  assign done_rise_c  = done & ~done_q;
  assign trial_diff_c = (sar_trial_value != dac_code);

  // State, counters and all output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      sample_cnt   <= '0;
      ones         <= '0;
      first_trial  <= 1'b1;
      done_q       <= 1'b0;
      dac_code     <= '0;
      dac_load     <= 1'b0;
      comp_out     <= 1'b0;
      comp_valid   <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      settle_cnt   <= settle_cnt_d;
      sample_cnt   <= sample_cnt_d;
      ones         <= ones_d;
      first_trial  <= first_trial_d;
      done_q       <= done;
      dac_code     <= dac_code_d;
      dac_load     <= dac_load_d;
      comp_out     <= comp_out_d;
      comp_valid   <= comp_valid_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      busy         <= busy_d;
    end
  end

  // Next state: done edge beats disable, which beats a trial change.
  always_comb begin
    state_d = state;
    if (done_rise_c) begin
      state_d = IDLE;
    end else if ((state != IDLE) && !enable) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:    if (enable && (first_trial || trial_diff_c)) state_d = LOAD;
        LOAD:    state_d = SETTLE;
        SETTLE:  if (trial_diff_c)                   state_d = LOAD;
                 else if (settle_cnt == SETTLE_LAST) state_d = SAMPLE;
        SAMPLE:  if (trial_diff_c)                   state_d = LOAD;
                 else if (sample_cnt == SAMPLE_LAST) state_d = DECIDE;
        DECIDE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values for counters, vote and outputs; any abort clears the vote.
  always_comb begin
    settle_cnt_d   = '0;
    sample_cnt_d   = '0;
    ones_d         = '0;
    first_trial_d  = first_trial;
    dac_code_d     = dac_code;
    dac_load_d     = 1'b0;
    comp_out_d     = comp_out;
    comp_valid_d   = 1'b0;
    result_d       = result;
    result_valid_d = 1'b0;
    busy_d         = (state_d != IDLE);

    if ((state == SETTLE) && (state_d == SETTLE)) settle_cnt_d = settle_cnt + SET_W'(1);
    if ((state == SAMPLE) && (state_d == SAMPLE)) sample_cnt_d = sample_cnt + SMP_W'(1);
    if ((state == SAMPLE) && ((state_d == SAMPLE) || (state_d == DECIDE)))
      ones_d = ones + VOTE_W'(comp_sync);

    if ((state == LOAD) && (state_d == SETTLE)) begin
      dac_code_d    = sar_trial_value;
      dac_load_d    = 1'b1;
      first_trial_d = 1'b0;
    end

    if ((state == DECIDE) && enable && !done_rise_c) begin
      comp_out_d   = (ones > VOTE_HALF);
      comp_valid_d = 1'b1;
    end

    if (done_rise_c) begin
      result_d       = sar_trial_value;
      result_valid_d = 1'b1;
      first_trial_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_sar_dac_comp_iface.sv
// Directed self-checking bench for sar_dac_comp_iface (default parameters).
module tb_sar_dac_comp_iface;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] sar_trial_value;
  logic       done;
  logic       comp_raw;
  logic [7:0] dac_code;
  logic       dac_load;
  logic       comp_out;
  logic       comp_valid;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Edge counter and pulse monitor, updated by tick().
  int         cyc = 0;
  int         dl_n, dl_at, cv_n, cv_at, rv_n, rv_at;
  logic [7:0] dl_code;

  sar_dac_comp_iface dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .sar_trial_value (sar_trial_value),
    .done            (done),
    .comp_raw        (comp_raw),
    .dac_code        (dac_code),
    .dac_load        (dac_load),
    .comp_out        (comp_out),
    .comp_valid      (comp_valid),
    .result          (result),
    .result_valid    (result_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_mon();
    dl_n = 0; dl_at = -1; cv_n = 0; cv_at = -1; rv_n = 0; rv_at = -1; dl_code = 8'h00;
  endtask

  // One rising edge; outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dac_load === 1'b1)     begin dl_n++; dl_at = cyc; dl_code = dac_code; end
    if (comp_valid === 1'b1)   begin cv_n++; cv_at = cyc; end
    if (result_valid === 1'b1) begin rv_n++; rv_at = cyc; end
  endtask

  // Full conversion; pat[2:0] is raw comparator on edges E4..E6 (seen by votes at E6..E8).
  task automatic convert(input logic [7:0] trial, input logic [2:0] pat, input logic others,
                         output int t0);
    clear_mon();
    enable = 1'b1;
    sar_trial_value = trial;
    t0 = cyc + 1;
    for (int k = 0; k < 14; k++) begin
      comp_raw = (k == 4) ? pat[2] : (k == 5) ? pat[1] : (k == 6) ? pat[0] : others;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; done = 1'b0; comp_raw = 1'b0; sar_trial_value = 8'h00;
    repeat (5) tick();
    reset = 1'b1;
    clear_mon();
    repeat (3) tick();
    if (dac_code !== 8'h00) begin n_bad++; $display("FAIL reset_dac_code: got %0h want 0", dac_code); end
    n_cmp++;
    if (comp_out !== 1'b0) begin n_bad++; $display("FAIL reset_comp_out: got %0b want 0", comp_out); end
    n_cmp++;
    if (result !== 8'h00) begin n_bad++; $display("FAIL reset_result: got %0h want 0", result); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++;
    if (dl_n + cv_n + rv_n !== 0) begin
      n_bad++; $display("FAIL reset_pulses: got %0d want 0", dl_n + cv_n + rv_n);
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    int t0;
    convert(8'h80, 3'b111, 1'b1, t0);
    if (dl_n !== 1) begin n_bad++; $display("FAIL basic_load_count: got %0d want 1", dl_n); end
    n_cmp++;
    if (dl_at - t0 !== 1) begin n_bad++; $display("FAIL basic_load_time: got %0d want 1", dl_at - t0); end
    n_cmp++;
    if (dl_code !== 8'h80) begin n_bad++; $display("FAIL basic_dac_code: got %0h want 80", dl_code); end
    n_cmp++;
    if (cv_n !== 1) begin n_bad++; $display("FAIL basic_valid_count: got %0d want 1", cv_n); end
    n_cmp++;
    if (cv_at - t0 !== 9) begin n_bad++; $display("FAIL basic_latency: got %0d want 9", cv_at - t0); end
    n_cmp++;
    if (comp_out !== 1'b1) begin n_bad++; $display("FAIL basic_comp_out: got %0b want 1", comp_out); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %0b want 0", busy); end
    n_cmp++;
  endtask

  task automatic test_vote();
    int t0;
    convert(8'h40, 3'b101, 1'b0, t0);
    if (comp_out !== 1'b1) begin n_bad++; $display("FAIL vote_101: got %0b want 1", comp_out); end
    n_cmp++;
    if (cv_n !== 1) begin n_bad++; $display("FAIL vote_101_count: got %0d want 1", cv_n); end
    n_cmp++;
    convert(8'h20, 3'b010, 1'b1, t0);
    if (comp_out !== 1'b0) begin n_bad++; $display("FAIL vote_010: got %0b want 0", comp_out); end
    n_cmp++;
    if (cv_at - t0 !== 9) begin n_bad++; $display("FAIL vote_010_latency: got %0d want 9", cv_at - t0); end
    n_cmp++;
    if (dac_code !== 8'h20) begin n_bad++; $display("FAIL vote_dac_code: got %0h want 20", dac_code); end
    n_cmp++;
  endtask

  task automatic test_trial_change();
    int tc;
    clear_mon();
    enable = 1'b1; comp_raw = 1'b1; sar_trial_value = 8'hC0;
    repeat (3) tick();                 // E0 LOAD, E1 SETTLE, E2 settling
    sar_trial_value = 8'hA0;
    tc = cyc + 1;
    repeat (15) tick();
    if (dl_n !== 2) begin n_bad++; $display("FAIL change_load_count: got %0d want 2", dl_n); end
    n_cmp++;
    if (dl_code !== 8'hA0) begin n_bad++; $display("FAIL change_second_code: got %0h want a0", dl_code); end
    n_cmp++;
    if (dl_at - tc !== 1) begin n_bad++; $display("FAIL change_load_time: got %0d want 1", dl_at - tc); end
    n_cmp++;
    if (cv_n !== 1) begin n_bad++; $display("FAIL change_valid_count: got %0d want 1", cv_n); end
    n_cmp++;
    if (cv_at - tc !== 9) begin n_bad++; $display("FAIL change_latency: got %0d want 9", cv_at - tc); end
    n_cmp++;
    if (comp_out !== 1'b1) begin n_bad++; $display("FAIL change_comp_out: got %0b want 1", comp_out); end
    n_cmp++;
  endtask

  task automatic test_done();
    clear_mon();
    enable = 1'b1; comp_raw = 1'b0; sar_trial_value = 8'h33;
    repeat (7) tick();                 // E0..E6, now in SAMPLE
    sar_trial_value = 8'h5A;
    done = 1'b1;
    tick();
    if (result_valid !== 1'b1) begin n_bad++; $display("FAIL done_pulse: got %0b want 1", result_valid); end
    n_cmp++;
    if (result !== 8'h5A) begin n_bad++; $display("FAIL done_result: got %0h want 5a", result); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL done_busy: got %0b want 0", busy); end
    n_cmp++;
    enable = 1'b0;
    repeat (2) tick();                 // done still held high
    done = 1'b0;
    repeat (12) tick();
    if (rv_n !== 1) begin n_bad++; $display("FAIL done_pulse_count: got %0d want 1", rv_n); end
    n_cmp++;
    if (cv_n !== 0) begin n_bad++; $display("FAIL done_no_valid: got %0d want 0", cv_n); end
    n_cmp++;
    if (comp_out !== 1'b1) begin n_bad++; $display("FAIL done_comp_hold: got %0b want 1", comp_out); end
    n_cmp++;
    if (dac_code !== 8'h33) begin n_bad++; $display("FAIL done_dac_hold: got %0h want 33", dac_code); end
    n_cmp++;
  endtask

  task automatic test_abort_reset();
    clear_mon();
    enable = 1'b1; comp_raw = 1'b0; sar_trial_value = 8'h66;
    repeat (3) tick();                 // in SETTLE
    enable = 1'b0;
    tick();
    if (busy !== 1'b0) begin n_bad++; $display("FAIL disable_busy: got %0b want 0", busy); end
    n_cmp++;
    if (dac_code !== 8'h66) begin n_bad++; $display("FAIL disable_dac_hold: got %0h want 66", dac_code); end
    n_cmp++;
    repeat (12) tick();
    if (cv_n !== 0) begin n_bad++; $display("FAIL disable_no_valid: got %0d want 0", cv_n); end
    n_cmp++;
    if (comp_out !== 1'b1) begin n_bad++; $display("FAIL disable_comp_hold: got %0b want 1", comp_out); end
    n_cmp++;

    clear_mon();
    enable = 1'b1; comp_raw = 1'b1; sar_trial_value = 8'h77;
    repeat (7) tick();                 // in SAMPLE
    reset = 1'b0;
    tick();
    if (dac_code !== 8'h00) begin n_bad++; $display("FAIL rst_dac_code: got %0h want 0", dac_code); end
    n_cmp++;
    if (comp_out !== 1'b0) begin n_bad++; $display("FAIL rst_comp_out: got %0b want 0", comp_out); end
    n_cmp++;
    if (result !== 8'h00) begin n_bad++; $display("FAIL rst_result: got %0h want 0", result); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++;
    reset = 1'b1; enable = 1'b0;
    repeat (12) tick();
    if (cv_n + rv_n !== 0) begin n_bad++; $display("FAIL rst_no_pulses: got %0d want 0", cv_n + rv_n); end
    n_cmp++;
    if (dl_n !== 1) begin n_bad++; $display("FAIL rst_load_count: got %0d want 1", dl_n); end
    n_cmp++;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_vote();
    test_trial_change();
    test_done();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
